lsb_serializer: RTL and testbench
=================================

Name: lsb_serializer

Overview:
- Parallel-to-serial front end for the bit-serial arithmetic path.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it LSB-first, one bit per clock.
- Pulses a clear strobe immediately before each word so the downstream serial two's-complement stage starts every word from a clean state.
- Its ser_bit, ser_valid and clr_out outputs drive the complement stage's data_in and clr inputs, plus its output-qualification logic, directly.

Parameters:
- WIDTH, 8, word length in bits; legal range is 2 or more.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream word valid.
- in_data  in  WIDTH  word to serialize; bit 0 is sent first.
- in_ready  out  1  block can accept a word; high only in IDLE.
- abort  in  1  synchronous cancel of the word in flight.
- clr_out  out  1  one-cycle clear strobe for the downstream serial stage.
- ser_bit  out  1  current serial bit.
- ser_valid  out  1  ser_bit carries a word bit this cycle.
- ser_last  out  1  high with the final bit (bit WIDTH-1) of the word.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE, shift register=0, counter=0, in_ready=1, clr_out=0, ser_bit=0, ser_valid=0, ser_last=0, busy=0.
- All outputs except in_ready are registered. in_ready is decoded directly from state==IDLE.
- State machine: IDLE, CLEAR, SHIFT.
- IDLE -> CLEAR:
  - Taken on the edge where in_valid && in_ready (the accept edge, end of cycle T).
  - in_data is captured into the shift register; the counter is zeroed.
- CLEAR (cycle T+1):
  - clr_out=1, ser_valid=0, ser_bit=0.
  - Always lasts exactly one cycle, then the block moves to SHIFT.
- SHIFT (cycles T+2 .. T+WIDTH+1):
  - ser_bit = shift register bit 0; ser_valid=1.
  - Each edge shifts the register right by one, filling with 0, and increments the counter.
  - ser_last=1 when counter==WIDTH-1.
  - On the edge ending the last-bit cycle, the block goes to IDLE.
- Latency: accept edge to first bit is 2 cycles. Word occupancy is WIDTH+1 cycles.
- Throughput: the earliest next accept is the edge ending cycle T+WIDTH+2, so there is one IDLE cycle between words. Each word costs WIDTH+2 cycles.
- Gap rule: whenever ser_valid=0, ser_bit is driven 0. The downstream stage advances every clock with no stall input, so a 0 input preserves its state.
- No stall capability: once SHIFT begins, bits leave on consecutive cycles unconditionally.
- in_valid while busy is ignored; the word is neither captured nor acknowledged.
- abort:
  - In CLEAR or SHIFT, abort forces IDLE on the next edge.
  - All registered outputs take their reset values on that edge; the partial word is discarded.
  - abort in IDLE has no effect and takes priority over a same-cycle accept (no capture).
- rst mid-operation: same effect as abort. rst has priority over everything.
- Downstream alignment: the complement stage's result for bit k appears one cycle after ser_bit carries bit k. Consumers delay ser_valid and ser_last by one cycle to qualify it.

Decomposition:
- Shared package (serial_pkg) holds:
  - the state encoding localparams ST_IDLE=2'd0, ST_CLEAR=2'd1, ST_SHIFT=2'd2;
  - the default word-width constant, shared with the complement and deserializer stages.
- Single module; no sub-module is warranted. The counter and shift register are inline.

Test Plan:
- Single word: WIDTH=8, accept 0x06. Expect clr_out high during T+1, then ser_bit sequence 0,1,1,0,0,0,0,0 with ser_valid high for 8 cycles and ser_last on the 8th. Complement output, reassembled, must equal 0xFA.
- Back-to-back: in_valid held high with 0x01 then 0x80. Expect in_ready low for 9 cycles after the first accept. The second accept lands exactly at T+WIDTH+2, and a second clr_out pulse precedes 0x80's bits. Complement results are 0xFF and 0x80.
- Edge values: 0x00 gives all-zero bits with ser_valid high for 8 cycles, and the complement result is 0x00. 0xFF gives a complement result of 0x01.
- Busy collision: present 0x55 during SHIFT of 0x33. Expect 0x55 ignored and in_ready=0; only 0x33's bits 1,1,0,0,1,1,0,0 appear.
- Reset mid-word: assert rst during the 4th SHIFT cycle. Expect all outputs at reset values on the next edge and in_ready=1. A fresh word 0x0F then serializes correctly, including its clr_out pulse.
- Abort: assert abort in CLEAR. Expect no ser_valid cycles and IDLE on the next edge. An abort raised in IDLE together with in_valid causes no capture.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial arithmetic path.
// Holds the FSM state encoding and the default word width that the
// serializer, complement and deserializer stages agree on.
package serial_pkg;

  // Default word length shared by all serial-path stages.
  localparam int unsigned SERIAL_WIDTH = 8;

  // State encoding of the serializer FSM.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    CLEAR = ST_CLEAR,
    SHIFT = ST_SHIFT
  } ser_state_e;

endpackage

// File: rtl/lsb_serializer.sv
// Parallel-to-serial front end: accepts a WIDTH-bit word on a valid/ready
// handshake, pulses clr_out for one cycle, then emits the word LSB-first,
// one bit per clock, with no stall capability.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_valid/in_data/in_ready  upstream word handshake (ready only in IDLE)
//   abort           cancels the word in flight
//   clr_out         one-cycle clear strobe for the downstream stage
//   ser_bit/ser_valid/ser_last  serial bit stream, last marks bit WIDTH-1
//   busy            high whenever not IDLE
module lsb_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             clr_out,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clr_d, bit_d, valid_d, last_d, busy_d;

  assign in_ready = (state_q == IDLE);

  // Next state, datapath and output decode. Outputs are derived from the
  // next-state values so that the registered outputs line up with the
  // state they describe.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        // abort in IDLE blocks a same-cycle accept
        if (in_valid && !abort) begin
          state_d = CLEAR;
          sh_d    = in_data;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        sh_d = {1'b0, sh_q[WIDTH-1:1]};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sh_d    = '0;
        cnt_d   = '0;
      end
    endcase

    // Discard the partial word; outputs fall back to reset values.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      sh_d    = '0;
      cnt_d   = '0;
    end

    clr_d   = (state_d == CLEAR);
    valid_d = (state_d == SHIFT);
    bit_d   = valid_d & sh_d[0];
    last_d  = valid_d && (cnt_d == CNT_W'(WIDTH - 1));
    busy_d  = (state_d != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      clr_out   <= 1'b0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      clr_out   <= clr_d;
      ser_bit   <= bit_d;
      ser_valid <= valid_d;
      ser_last  <= last_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_lsb_serializer.sv
// Self-checking bench for lsb_serializer (WIDTH=8). Expected streams come
// from the word value and cycle offset after the accept edge; a small
// serial two's-complement model consumes the DUT stream as the downstream
// stage would.
module tb_lsb_serializer;

  localparam int unsigned W = 8;
  localparam logic [5:0] IDLE_VEC = 6'b100000;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         abort;
  logic         clr_out;
  logic         ser_bit;
  logic         ser_valid;
  logic         ser_last;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] word_q[$];

  lsb_serializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .abort(abort), .clr_out(clr_out),
    .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_last(ser_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // {in_ready, busy, clr_out, ser_valid, ser_bit, ser_last}
  function automatic logic [5:0] obs();
    return {in_ready, busy, clr_out, ser_valid, ser_bit, ser_last};
  endfunction

  // Expected output vector c cycles after the accept edge of word w.
  function automatic logic [5:0] expect_vec(input logic [W-1:0] w, input int c);
    logic v;
    logic b;
    if (c < 1 || c > W + 1) return IDLE_VEC;
    v = (c >= 2);
    b = v ? w[c-2] : 1'b0;
    return {1'b0, 1'b1, (c == 1), v, b, (c == W + 1)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; abort = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (obs() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL reset: got %b want %b", obs(), IDLE_VEC);
    end
    rst = 1'b0;
    tick();
  endtask

  // Serializes every word in word_q with random idle gaps and checks each
  // cycle plus the downstream two's-complement result.
  task automatic test_words(input string name);
    logic [W-1:0] w, raw, comp;
    logic         seen;
    int           k;
    while (word_q.size() > 0) begin
      w = word_q.pop_front();
      repeat ($urandom_range(0, 2)) tick();
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s ready: got %b want 1", name, in_ready);
      end
      in_valid = 1'b1; in_data = w;
      tick();
      in_valid = 1'b0; in_data = W'($urandom);
      raw = '0; comp = '0; seen = 1'b0; k = 0;
      for (int c = 1; c <= W + 2; c++) begin
        n_tests++;
        if (obs() !== expect_vec(w, c)) begin
          n_fail++;
          $display("FAIL %s w=%h c=%0d: got %b want %b", name, w, c, obs(), expect_vec(w, c));
        end
        if (clr_out) begin
          seen = 1'b0; comp = '0; raw = '0; k = 0;
        end else if (ser_valid && k < W) begin
          raw[k]  = ser_bit;
          comp[k] = ser_bit ^ seen;
          seen    = seen | ser_bit;
          k++;
        end
        if (c < W + 2) tick();
      end
      n_tests++;
      if (raw !== w || comp !== W'(~w + 1'b1)) begin
        n_fail++;
        $display("FAIL %s result: got raw=%h comp=%h want raw=%h comp=%h", name, raw, comp, w, W'(~w + 1'b1));
      end
    end
  endtask

  task automatic test_single();
    word_q = '{8'h06};
    test_words("single");
  endtask

  task automatic test_edges();
    word_q = '{8'h00, 8'hFF, 8'h80, 8'h01};
    test_words("edge");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) word_q.push_back(W'($urandom));
    test_words("random");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] wa, wb, comp, e_comp;
    logic [5:0]   e;
    logic         seen, v;
    int           k;
    wa = 8'h01; wb = 8'h80;
    in_valid = 1'b1; in_data = wa;
    tick();
    in_data = wb;
    comp = '0; seen = 1'b0; k = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 11) in_valid = 1'b0;
      if (c <= 10) e = expect_vec(wa, c);
      else         e = expect_vec(wb, c - 10);
      if (c == 10) e[5] = 1'b1;
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL b2b c=%0d: got %b want %b", c, obs(), e);
      end
      if (clr_out) begin
        seen = 1'b0; comp = '0; k = 0;
      end else if (ser_valid && k < W) begin
        comp[k] = ser_bit ^ seen;
        seen    = seen | ser_bit;
        k++;
      end
      if (c == 10 || c == 20) begin
        e_comp = (c == 10) ? W'(~wa + 1'b1) : W'(~wb + 1'b1);
        n_tests++;
        if (comp !== e_comp) begin
          n_fail++;
          $display("FAIL b2b comp c=%0d: got %h want %h", c, comp, e_comp);
        end
      end
      v = (c < 20);
      if (v) tick();
    end
  endtask

  task automatic test_busy_collision();
    logic [W-1:0] w;
    w = 8'h33;
    in_valid = 1'b1; in_data = w;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= W + 3; c++) begin
      if (c == 4) begin in_valid = 1'b1; in_data = 8'h55; end
      if (c == W + 1) in_valid = 1'b0;
      n_tests++;
      if (obs() !== expect_vec(w, c)) begin
        n_fail++;
        $display("FAIL collision c=%0d: got %b want %b", c, obs(), expect_vec(w, c));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    w = W'($urandom) | 8'h10;
    in_valid = 1'b1; in_data = w;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      n_tests++;
      if (obs() !== expect_vec(w, c)) begin
        n_fail++;
        $display("FAIL rst_mid c=%0d: got %b want %b", c, obs(), expect_vec(w, c));
      end
      if (c == 5) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    n_tests++;
    if (obs() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL rst_mid idle: got %b want %b", obs(), IDLE_VEC);
    end
    word_q = '{8'h0F};
    test_words("after_rst");
  endtask

  task automatic test_abort();
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (obs() !== expect_vec(8'hA5, 1)) begin
      n_fail++;
      $display("FAIL abort clear: got %b want %b", obs(), expect_vec(8'hA5, 1));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int c = 0; c < W + 2; c++) begin
      n_tests++;
      if (obs() !== IDLE_VEC) begin
        n_fail++;
        $display("FAIL abort idle c=%0d: got %b want %b", c, obs(), IDLE_VEC);
      end
      tick();
    end
    // abort in IDLE with a same-cycle valid: no capture
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h3C;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (obs() !== IDLE_VEC) begin
        n_fail++;
        $display("FAIL abort_idle c=%0d: got %b want %b", c, obs(), IDLE_VEC);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    tick();
    test_edges();
    test_busy_collision();
    test_reset_mid();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
